// File: rtl/leiwand_rv32_wb_arbiter.sv
// Two-master, one-slave pipelined Wishbone arbiter: round-robin per CYC envelope,
// one-entry request buffer for the grant cycle, and a no-ack watchdog.
module leiwand_rv32_wb_arbiter #(
  parameter int unsigned MEM_WIDTH      = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_m0_cyc,
  input  logic                 i_m0_stb,
  input  logic                 i_m0_we,
  input  logic [MEM_WIDTH-1:0] i_m0_addr,
  input  logic [MEM_WIDTH-1:0] i_m0_data,
  input  logic                 i_m1_cyc,
  input  logic                 i_m1_stb,
  input  logic                 i_m1_we,
  input  logic [MEM_WIDTH-1:0] i_m1_addr,
  input  logic [MEM_WIDTH-1:0] i_m1_data,
  output logic                 o_m0_ack,
  output logic                 o_m0_stall,
  output logic                 o_m0_err,
  output logic [MEM_WIDTH-1:0] o_m0_data,
  output logic                 o_m1_ack,
  output logic                 o_m1_stall,
  output logic                 o_m1_err,
  output logic [MEM_WIDTH-1:0] o_m1_data,
  output logic                 o_s_cyc,
  output logic                 o_s_stb,
  output logic                 o_s_we,
  output logic [MEM_WIDTH-1:0] o_s_addr,
  output logic [MEM_WIDTH-1:0] o_s_data,
  input  logic                 i_s_ack,
  input  logic                 i_s_stall,
  input  logic [MEM_WIDTH-1:0] i_s_data
);

  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT_CYCLES);
  localparam bit               WDOG_EN     = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic                 we;
    logic [MEM_WIDTH-1:0] addr;
    logic [MEM_WIDTH-1:0] data;
  } req_t;

  state_t           state, state_nxt;
  logic             owner, owner_nxt;
  logic             last_owner, last_owner_nxt;
  logic             buf_valid, buf_valid_nxt;
  req_t             buf_req, buf_req_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  req_t m0_req, m1_req, own_req, win_req;
  logic winner, win_stb, own_cyc, own_stb, own_stall;
  logic timeout_hit, err_hit;

  assign m0_req = {i_m0_we, i_m0_addr, i_m0_data};
  assign m1_req = {i_m1_we, i_m1_addr, i_m1_data};

  // On a tie the master that did not own the bus last time wins (0 = M0, 1 = M1).
  assign winner  = (i_m0_cyc & i_m1_cyc) ? ~last_owner : ~i_m0_cyc;
  assign win_stb = winner ? i_m1_stb : i_m0_stb;
  assign win_req = winner ? m1_req : m0_req;

  assign own_cyc = owner ? i_m1_cyc : i_m0_cyc;
  assign own_stb = owner ? i_m1_stb : i_m0_stb;
  assign own_req = owner ? m1_req : m0_req;

  assign timeout_hit = WDOG_EN && (cnt == TIMEOUT_CNT);
  assign err_hit     = (state == BUSY) & timeout_hit & own_cyc & ~i_s_ack;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      buf_valid  <= 1'b0;
      buf_req    <= '0;
      cnt        <= '0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_owner <= last_owner_nxt;
      buf_valid  <= buf_valid_nxt;
      buf_req    <= buf_req_nxt;
      cnt        <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_owner_nxt = last_owner;
    buf_valid_nxt  = buf_valid;
    buf_req_nxt    = buf_req;
    cnt_nxt        = cnt;
    own_stall      = 1'b1;
    o_s_cyc        = 1'b0;
    o_s_stb        = 1'b0;
    o_s_we         = 1'b0;
    o_s_addr       = '0;
    o_s_data       = '0;
    o_m0_ack       = 1'b0;
    o_m1_ack       = 1'b0;
    o_m0_err       = 1'b0;
    o_m1_err       = 1'b0;
    o_m0_data      = '0;
    o_m1_data      = '0;
    o_m0_stall     = 1'b0;
    o_m1_stall     = 1'b0;

    unique case (state)
      IDLE: begin
        o_m0_stall = i_m0_cyc & winner;
        o_m1_stall = i_m1_cyc & ~winner;
        if (i_m0_cyc | i_m1_cyc) begin
          state_nxt      = BUSY;
          owner_nxt      = winner;
          last_owner_nxt = winner;
          cnt_nxt        = '0;
          buf_valid_nxt  = win_stb;
          buf_req_nxt    = win_req;
        end
      end

      BUSY: begin
        o_s_cyc = 1'b1;
        // The buffered strobe goes out first; the owner is held off until it drains.
        if (buf_valid) begin
          o_s_stb   = 1'b1;
          o_s_we    = buf_req.we;
          o_s_addr  = buf_req.addr;
          o_s_data  = buf_req.data;
          own_stall = 1'b1;
          if (!i_s_stall) buf_valid_nxt = 1'b0;
        end else begin
          o_s_stb   = own_stb;
          o_s_we    = own_req.we;
          o_s_addr  = own_req.addr;
          o_s_data  = own_req.data;
          own_stall = i_s_stall;
        end
        o_m0_stall = owner ? 1'b1 : own_stall;
        o_m1_stall = owner ? own_stall : 1'b1;
        o_m0_ack   = ~owner & i_s_ack;
        o_m1_ack   = owner & i_s_ack;
        o_m0_data  = owner ? '0 : i_s_data;
        o_m1_data  = owner ? i_s_data : '0;
        o_m0_err   = ~owner & err_hit;
        o_m1_err   = owner & err_hit;

        // Owner release beats an ack, which beats the watchdog.
        if (!own_cyc) begin
          state_nxt     = IDLE;
          buf_valid_nxt = 1'b0;
        end else if (i_s_ack) begin
          cnt_nxt = '0;
        end else if (timeout_hit) begin
          state_nxt     = DRAIN;
          buf_valid_nxt = 1'b0;
        end else if (cnt != CNT_MAX) begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      DRAIN: begin
        o_m0_stall = 1'b1;
        o_m1_stall = 1'b1;
        if (!own_cyc) state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Outputs go quiet the moment reset asserts, independent of the clock.
    if (!i_rst_n) begin
      o_s_cyc    = 1'b0;
      o_s_stb    = 1'b0;
      o_s_we     = 1'b0;
      o_s_addr   = '0;
      o_s_data   = '0;
      o_m0_ack   = 1'b0;
      o_m1_ack   = 1'b0;
      o_m0_err   = 1'b0;
      o_m1_err   = 1'b0;
      o_m0_data  = '0;
      o_m1_data  = '0;
      o_m0_stall = 1'b0;
      o_m1_stall = 1'b0;
    end
  end

endmodule

// File: tb/tb_leiwand_rv32_wb_arbiter.sv
// Self-checking bench for leiwand_rv32_wb_arbiter: directed scenarios plus a
// randomized run against a transaction-level ownership model.
module tb_leiwand_rv32_wb_arbiter;

  localparam int unsigned W  = 32;
  localparam int unsigned TO = 4;

  logic         clk, rst_n;
  logic         m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [W-1:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic         m0_ack, m0_stall, m0_err, m1_ack, m1_stall, m1_err;
  logic [W-1:0] m0_rdata, m1_rdata;
  logic         s_cyc, s_stb, s_we, s_ack, s_stall;
  logic [W-1:0] s_addr, s_wdata, s_rdata;

  int checks = 0;
  int errors = 0;

  leiwand_rv32_wb_arbiter #(.MEM_WIDTH(W), .TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_m0_cyc(m0_cyc), .i_m0_stb(m0_stb), .i_m0_we(m0_we), .i_m0_addr(m0_addr), .i_m0_data(m0_wdata),
    .i_m1_cyc(m1_cyc), .i_m1_stb(m1_stb), .i_m1_we(m1_we), .i_m1_addr(m1_addr), .i_m1_data(m1_wdata),
    .o_m0_ack(m0_ack), .o_m0_stall(m0_stall), .o_m0_err(m0_err), .o_m0_data(m0_rdata),
    .o_m1_ack(m1_ack), .o_m1_stall(m1_stall), .o_m1_err(m1_err), .o_m1_data(m1_rdata),
    .o_s_cyc(s_cyc), .o_s_stb(s_stb), .o_s_we(s_we), .o_s_addr(s_addr), .o_s_data(s_wdata),
    .i_s_ack(s_ack), .i_s_stall(s_stall), .i_s_data(s_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL sim_timeout: simulation exceeded its time budget");
    $fatal(1);
  end

  task automatic idle_inputs();
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    s_ack = 0; s_stall = 0; s_rdata = '0;
  endtask

  // Advance one full cycle, landing on the next falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    m0_cyc = 1; m1_cyc = 1; m0_stb = 1; m0_addr = 32'h1234_5678; s_ack = 1; s_rdata = 32'h5;
    #1;
    checks++; if ({s_cyc, s_stb, s_we} !== 3'b000) begin errors++; $display("FAIL reset_s_ctl got %b exp 000", {s_cyc, s_stb, s_we}); end
    checks++; if (s_addr !== '0 || s_wdata !== '0) begin errors++; $display("FAIL reset_s_bus got %h/%h exp 0", s_addr, s_wdata); end
    checks++; if ({m0_stall, m1_stall} !== 2'b00) begin errors++; $display("FAIL reset_stall got %b exp 00", {m0_stall, m1_stall}); end
    checks++; if ({m0_ack, m1_ack, m0_err, m1_err} !== 4'b0000) begin errors++; $display("FAIL reset_ack_err got %b exp 0000", {m0_ack, m1_ack, m0_err, m1_err}); end
    checks++; if (m0_rdata !== '0 || m1_rdata !== '0) begin errors++; $display("FAIL reset_rdata got %h/%h exp 0", m0_rdata, m1_rdata); end
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_single_read();
    m0_cyc = 1; m0_stb = 1; m0_addr = 32'h1000_0000;
    #1;
    checks++; if (m0_stall !== 1'b0) begin errors++; $display("FAIL rd_grant_stall got %b exp 0", m0_stall); end
    checks++; if (s_stb !== 1'b0 || s_cyc !== 1'b0) begin errors++; $display("FAIL rd_idle_slave got cyc=%b stb=%b exp 0", s_cyc, s_stb); end
    tick(); m0_stb = 0; #1;
    checks++; if (s_cyc !== 1'b1 || s_stb !== 1'b1) begin errors++; $display("FAIL rd_slave_stb got cyc=%b stb=%b exp 1", s_cyc, s_stb); end
    checks++; if (s_addr !== 32'h1000_0000) begin errors++; $display("FAIL rd_slave_addr got %h exp 10000000", s_addr); end
    tick(); s_ack = 1; s_rdata = 32'hDEAD_BEEF; #1;
    checks++; if (m0_ack !== 1'b1) begin errors++; $display("FAIL rd_m0_ack got %b exp 1", m0_ack); end
    checks++; if (m0_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_m0_data got %h exp deadbeef", m0_rdata); end
    checks++; if (m1_ack !== 1'b0 || m1_rdata !== '0) begin errors++; $display("FAIL rd_m1_quiet got ack=%b data=%h exp 0", m1_ack, m1_rdata); end
    tick(); s_ack = 0; m0_cyc = 0; #1;
    tick(); #1;
    checks++; if (s_cyc !== 1'b0) begin errors++; $display("FAIL rd_release got cyc=%b exp 0", s_cyc); end
  endtask

  task automatic test_tie();
    do_reset();
    m0_cyc = 1; m0_stb = 1; m0_addr = 32'h1000_0100;
    m1_cyc = 1; m1_stb = 1; m1_addr = 32'h2000_0004;
    #1;
    checks++; if ({m0_stall, m1_stall} !== 2'b01) begin errors++; $display("FAIL tie1_stall got %b exp 01", {m0_stall, m1_stall}); end
    tick(); m0_stb = 0; #1;
    checks++; if (s_addr !== 32'h1000_0100 || m1_stall !== 1'b1) begin errors++; $display("FAIL tie1_owner got addr=%h m1_stall=%b exp 10000100/1", s_addr, m1_stall); end
    tick(); m0_cyc = 0; #1;
    tick(); #1;
    checks++; if (m1_stall !== 1'b0 || s_cyc !== 1'b0) begin errors++; $display("FAIL tie1_m1_grant got stall=%b cyc=%b exp 0/0", m1_stall, s_cyc); end
    tick(); m1_stb = 0; #1;
    checks++; if (s_addr !== 32'h2000_0004 || s_stb !== 1'b1) begin errors++; $display("FAIL tie1_m1_slave got addr=%h stb=%b exp 20000004/1", s_addr, s_stb); end
    tick(); m1_cyc = 0; #1;
    tick();
    m0_cyc = 1; m1_cyc = 1; #1;
    checks++; if ({m0_stall, m1_stall} !== 2'b01) begin errors++; $display("FAIL tie2_stall got %b exp 01", {m0_stall, m1_stall}); end
    tick(); #1;
    checks++; if (s_cyc !== 1'b1 || m0_stall !== 1'b0 || m1_stall !== 1'b1) begin errors++; $display("FAIL tie2_owner got cyc=%b stall=%b%b exp 1 01", s_cyc, m0_stall, m1_stall); end
    m0_cyc = 0; m1_cyc = 0;
    tick();
  endtask

  task automatic test_buffer_stall();
    m1_cyc = 1; m1_stb = 1; m1_addr = 32'h3000_0008; s_stall = 1; #1;
    checks++; if (m1_stall !== 1'b0) begin errors++; $display("FAIL buf_grant got stall=%b exp 0", m1_stall); end
    tick(); m1_stb = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (s_stb !== 1'b1 || s_addr !== 32'h3000_0008 || m1_stall !== 1'b1) begin errors++; $display("FAIL buf_hold%0d got stb=%b addr=%h stall=%b exp 1/30000008/1", k, s_stb, s_addr, m1_stall); end
      tick();
    end
    s_stall = 0; #1;
    checks++; if (s_stb !== 1'b1 || s_addr !== 32'h3000_0008 || m1_stall !== 1'b1) begin errors++; $display("FAIL buf_drain got stb=%b addr=%h stall=%b exp 1/30000008/1", s_stb, s_addr, m1_stall); end
    tick(); #1;
    checks++; if (s_stb !== 1'b0 || m1_stall !== 1'b0) begin errors++; $display("FAIL buf_empty got stb=%b stall=%b exp 0/0", s_stb, m1_stall); end
    m1_cyc = 0;
    tick();
  endtask

  task automatic test_watchdog();
    m0_cyc = 1; m0_stb = 1; m0_addr = 32'h1000_0200; #1;
    tick(); m0_stb = 0;
    for (int b = 0; b <= int'(TO); b++) begin
      if (b == 1) m1_cyc = 1;
      #1;
      checks++; if (m0_err !== (b == int'(TO)) || m1_err !== 1'b0) begin errors++; $display("FAIL wd_err_b%0d got %b%b exp %b0", b, m0_err, m1_err, (b == int'(TO))); end
      checks++; if (s_cyc !== 1'b1) begin errors++; $display("FAIL wd_cyc_b%0d got %b exp 1", b, s_cyc); end
      tick();
    end
    #1;
    checks++; if (m0_err !== 1'b0 || s_cyc !== 1'b0 || s_stb !== 1'b0) begin errors++; $display("FAIL wd_drain got err=%b cyc=%b stb=%b exp 000", m0_err, s_cyc, s_stb); end
    checks++; if ({m0_stall, m1_stall} !== 2'b11) begin errors++; $display("FAIL wd_drain_stall got %b exp 11", {m0_stall, m1_stall}); end
    tick(); #1;
    checks++; if (s_cyc !== 1'b0 || m1_stall !== 1'b1) begin errors++; $display("FAIL wd_hold got cyc=%b m1_stall=%b exp 0/1", s_cyc, m1_stall); end
    m0_cyc = 0; #1;
    checks++; if (m1_stall !== 1'b1) begin errors++; $display("FAIL wd_release_cycle got m1_stall=%b exp 1", m1_stall); end
    tick(); #1;
    checks++; if (m1_stall !== 1'b0) begin errors++; $display("FAIL wd_m1_grant got %b exp 0", m1_stall); end
    tick(); #1;
    checks++; if (s_cyc !== 1'b1 || m1_stall !== 1'b0) begin errors++; $display("FAIL wd_m1_busy got cyc=%b stall=%b exp 1/0", s_cyc, m1_stall); end
    m1_cyc = 0;
    tick();
  endtask

  task automatic test_ack_race();
    m0_cyc = 1; m0_stb = 1; m0_addr = 32'h1000_0300; #1;
    tick(); m0_stb = 0;
    repeat (TO) tick();
    s_ack = 1; s_rdata = 32'hCAFE_F00D; #1;
    checks++; if (m0_ack !== 1'b1 || m0_err !== 1'b0) begin errors++; $display("FAIL race_ack got ack=%b err=%b exp 1/0", m0_ack, m0_err); end
    checks++; if (m0_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL race_data got %h exp cafef00d", m0_rdata); end
    tick(); s_ack = 0; #1;
    checks++; if (s_cyc !== 1'b1 || m0_err !== 1'b0 || m0_stall !== 1'b0) begin errors++; $display("FAIL race_busy got cyc=%b err=%b stall=%b exp 1/0/0", s_cyc, m0_err, m0_stall); end
    m0_cyc = 0;
    tick();
  endtask

  task automatic test_reset_mid();
    m0_cyc = 1; m0_stb = 1; m0_addr = 32'h1000_0400; m0_we = 1; m0_wdata = 32'h55AA_55AA; #1;
    tick(); #1;
    checks++; if (s_cyc !== 1'b1 || s_stb !== 1'b1) begin errors++; $display("FAIL rmid_busy got cyc=%b stb=%b exp 1/1", s_cyc, s_stb); end
    rst_n = 0; s_ack = 1; #1;
    checks++; if ({s_cyc, s_stb, s_we} !== 3'b000 || s_addr !== '0 || s_wdata !== '0) begin errors++; $display("FAIL rmid_slave got %b %h %h exp 000 0 0", {s_cyc, s_stb, s_we}, s_addr, s_wdata); end
    checks++; if ({m0_ack, m0_err, m1_ack, m1_err} !== 4'b0000) begin errors++; $display("FAIL rmid_resp got %b exp 0000", {m0_ack, m0_err, m1_ack, m1_err}); end
    idle_inputs();
    @(negedge clk);
    rst_n = 1;
    m0_cyc = 1; m1_cyc = 1; #1;
    checks++; if ({m0_stall, m1_stall} !== 2'b01) begin errors++; $display("FAIL rmid_tie got %b exp 01", {m0_stall, m1_stall}); end
    m0_cyc = 0; m1_cyc = 0;
    tick();
  endtask

  typedef struct {
    logic         we;
    logic [W-1:0] addr;
    logic [W-1:0] data;
  } req_t;

  // Reference: who holds the bus, whether it is being drained after an abort,
  // the one strobe waiting from the grant cycle, and cycles since the last ack.
  task automatic test_random();
    int   owner, last, since;
    bit   drain;
    req_t pend[$];
    logic mc[2], ms[2], mw[2];
    logic [W-1:0] ma[2], md[2];
    int   win;
    logic e_cyc, e_stb, e_we;
    logic [W-1:0] e_addr, e_wd;
    logic e_stall[2], e_ack[2], e_err[2];
    logic [W-1:0] e_rd[2];
    logic g_stall[2], g_ack[2], g_err[2];
    logic [W-1:0] g_rd[2];
    req_t r;

    do_reset();
    owner = -1; last = 1; since = 0; drain = 0; pend.delete();
    mc[0] = 0; mc[1] = 0;
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 2; i++) begin
        mc[i] = mc[i] ? ($urandom_range(0, 5) != 0) : ($urandom_range(0, 2) == 0);
        ms[i] = mc[i] & $urandom_range(0, 1);
        mw[i] = $urandom_range(0, 1);
        ma[i] = $urandom;
        md[i] = $urandom;
      end
      m0_cyc = mc[0]; m0_stb = ms[0]; m0_we = mw[0]; m0_addr = ma[0]; m0_wdata = md[0];
      m1_cyc = mc[1]; m1_stb = ms[1]; m1_we = mw[1]; m1_addr = ma[1]; m1_wdata = md[1];
      s_ack = ($urandom_range(0, 3) == 0);
      s_stall = ($urandom_range(0, 3) == 0);
      s_rdata = $urandom;

      win = (mc[0] && mc[1]) ? 1 - last : (mc[0] ? 0 : (mc[1] ? 1 : -1));
      e_cyc = 0; e_stb = 0; e_we = 0; e_addr = '0; e_wd = '0;
      for (int i = 0; i < 2; i++) begin
        e_stall[i] = 0; e_ack[i] = 0; e_err[i] = 0; e_rd[i] = '0;
      end
      if (owner < 0) begin
        for (int i = 0; i < 2; i++) e_stall[i] = mc[0] && mc[1] && (win != i);
      end else if (drain) begin
        e_stall[0] = 1; e_stall[1] = 1;
      end else begin
        e_cyc = 1;
        e_stall[1 - owner] = 1;
        if (pend.size() > 0) begin
          e_stb = 1; e_we = pend[0].we; e_addr = pend[0].addr; e_wd = pend[0].data;
          e_stall[owner] = 1;
        end else begin
          e_stb = ms[owner]; e_we = mw[owner]; e_addr = ma[owner]; e_wd = md[owner];
          e_stall[owner] = s_stall;
        end
        e_ack[owner] = s_ack;
        e_rd[owner] = s_rdata;
        e_err[owner] = (since == int'(TO)) && !s_ack && mc[owner];
      end

      #1;
      g_stall[0] = m0_stall; g_stall[1] = m1_stall;
      g_ack[0] = m0_ack; g_ack[1] = m1_ack;
      g_err[0] = m0_err; g_err[1] = m1_err;
      g_rd[0] = m0_rdata; g_rd[1] = m1_rdata;
      checks++; if (s_cyc !== e_cyc || s_stb !== e_stb) begin errors++; $display("FAIL rnd%0d_s_ctl got cyc=%b stb=%b exp %b/%b", n, s_cyc, s_stb, e_cyc, e_stb); end
      if (e_stb) begin
        checks++; if (s_addr !== e_addr || s_wdata !== e_wd || s_we !== e_we) begin errors++; $display("FAIL rnd%0d_s_req got %b %h %h exp %b %h %h", n, s_we, s_addr, s_wdata, e_we, e_addr, e_wd); end
      end
      for (int i = 0; i < 2; i++) begin
        checks++; if (g_stall[i] !== e_stall[i]) begin errors++; $display("FAIL rnd%0d_m%0d_stall got %b exp %b", n, i, g_stall[i], e_stall[i]); end
        checks++; if (g_ack[i] !== e_ack[i] || g_err[i] !== e_err[i]) begin errors++; $display("FAIL rnd%0d_m%0d_resp got ack=%b err=%b exp %b/%b", n, i, g_ack[i], g_err[i], e_ack[i], e_err[i]); end
        checks++; if (g_rd[i] !== e_rd[i]) begin errors++; $display("FAIL rnd%0d_m%0d_data got %h exp %h", n, i, g_rd[i], e_rd[i]); end
      end

      @(posedge clk);
      if (owner < 0) begin
        if (win >= 0) begin
          owner = win; last = win; since = 0;
          if (ms[win]) begin
            r.we = mw[win]; r.addr = ma[win]; r.data = md[win];
            pend.push_back(r);
          end
        end
      end else if (drain) begin
        if (!mc[owner]) begin owner = -1; drain = 0; end
      end else begin
        if (pend.size() > 0 && !s_stall) pend.delete();
        if (!mc[owner]) begin
          owner = -1; pend.delete();
        end else if (s_ack) begin
          since = 0;
        end else if (since == int'(TO)) begin
          drain = 1; pend.delete();
        end else if (since < 255) begin
          since++;
        end
      end
      @(negedge clk);
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    clk = 0;
    rst_n = 0;
    idle_inputs();
    test_reset();
    test_single_read();
    test_tie();
    test_buffer_stall();
    test_watchdog();
    test_ack_race();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
